// File: rtl/procb_buf_pkg.sv
// Shared definitions for the per-thread process_bytes record buffer.
// Record layout is {addr, bytes_left, finish_ctx}, MSB first.
package procb_buf_pkg;

  localparam int unsigned PROCB_N_THREADS  = 16;
  localparam int unsigned PROCB_DEPTH      = 4;
  localparam int unsigned PROCB_ADDR_W     = 32;
  localparam int unsigned PROCB_BYTES_W    = 16;
  localparam int unsigned PROCB_D_WIDTH    = PROCB_ADDR_W + PROCB_BYTES_W + 1;

  typedef struct packed {
    logic [PROCB_ADDR_W-1:0]  addr;
    logic [PROCB_BYTES_W-1:0] bytes_left;
    logic                     finish_ctx;
  } procb_rec_t;

endpackage

// File: rtl/procb_buf_ptr_file.sv
// Per-thread write/read pointers (with wrap bit) and the write-side full flag.
module procb_ptr_file #(
  parameter int unsigned N_THREADS = 16,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned TW        = $clog2(N_THREADS),
  parameter int unsigned PW        = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [TW-1:0] wr_thread_i,
  input  logic          wr_inc_i,
  input  logic [TW-1:0] rd_thread_i,
  input  logic          rd_inc_i,
  input  logic          rd_clr_i,
  output logic          wr_full_o,
  output logic [PW-1:0] wr_ptr_wt_o,
  output logic [PW-1:0] wr_ptr_rt_o,
  output logic [PW-1:0] rd_ptr_rt_o
);

  logic [PW-1:0] wr_ptr_q [N_THREADS];
  logic [PW-1:0] wr_ptr_d [N_THREADS];
  logic [PW-1:0] rd_ptr_q [N_THREADS];
  logic [PW-1:0] rd_ptr_d [N_THREADS];
  logic [PW-1:0] wt_count_c;

  // Clear is applied last so it overrides any same-cycle increment.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_inc_i) begin
      wr_ptr_d[wr_thread_i] = wr_ptr_q[wr_thread_i] + PW'(1);
    end
    if (rd_inc_i) begin
      rd_ptr_d[rd_thread_i] = rd_ptr_q[rd_thread_i] + PW'(1);
    end
    if (rd_clr_i) begin
      wr_ptr_d[rd_thread_i] = '0;
      rd_ptr_d[rd_thread_i] = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int t = 0; t < int'(N_THREADS); t++) begin
        wr_ptr_q[t] <= '0;
        rd_ptr_q[t] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  assign wt_count_c  = wr_ptr_q[wr_thread_i] - rd_ptr_q[wr_thread_i];
  assign wr_full_o   = (wt_count_c == PW'(DEPTH));
  assign wr_ptr_wt_o = wr_ptr_q[wr_thread_i];
  assign wr_ptr_rt_o = wr_ptr_q[rd_thread_i];
  assign rd_ptr_rt_o = rd_ptr_q[rd_thread_i];

endmodule

// File: rtl/procb_buf.sv
// Per-thread circular buffer of procb records between the command parser
// (writer) and the process_bytes engine (speculative lookup + commit reader).
module procb_buf
  import procb_buf_pkg::*;
#(
  parameter int unsigned N_THREADS     = PROCB_N_THREADS,
  parameter int unsigned N_THREADS_MSB = $clog2(N_THREADS) - 1,
  parameter int unsigned DEPTH         = PROCB_DEPTH,
  parameter int unsigned D_WIDTH       = PROCB_D_WIDTH
) (
  input  logic                   CLK,
  input  logic                   rst_n,
  input  logic [N_THREADS_MSB:0] wr_thread_num,
  input  logic                   wr_en,
  input  logic [D_WIDTH-1:0]     din,
  output logic                   wr_full,
  input  logic [N_THREADS_MSB:0] rd_thread_num,
  input  logic                   lookup_en,
  input  logic                   rd_en,
  input  logic                   rd_rst,
  output logic                   lookup_empty,
  output logic [D_WIDTH-1:0]     dout,
  output logic                   err
);

  localparam int unsigned TW          = N_THREADS_MSB + 1;
  localparam int unsigned PW          = $clog2(DEPTH) + 1;
  localparam int unsigned LW          = PW - 1;
  localparam int unsigned AW          = TW + LW;
  localparam int unsigned MEM_ENTRIES = N_THREADS * DEPTH;

  logic [D_WIDTH-1:0] mem [MEM_ENTRIES];

  logic [PW-1:0] wr_ptr_wt;
  logic [PW-1:0] wr_ptr_rt;
  logic [PW-1:0] rd_ptr_rt;
  logic [PW-1:0] lk_ptr_q, lk_ptr_d;
  logic [TW-1:0] prev_thread_q;
  logic          err_q, err_d;

  logic          rd_clr_c, reload_c, wr_kill_c, wr_do_c, wr_drop_c;
  logic          lk_do_c, lk_err_c, commit_c, commit_err_c, rd_inc_c;
  logic [PW-1:0] lk_eff_c;
  logic [AW-1:0] wr_addr_c, rd_addr_c;

  procb_ptr_file #(
    .N_THREADS (N_THREADS),
    .DEPTH     (DEPTH),
    .TW        (TW),
    .PW        (PW)
  ) u_ptr_file (
    .clk_i       (CLK),
    .rst_ni      (rst_n),
    .wr_thread_i (wr_thread_num),
    .wr_inc_i    (wr_do_c),
    .rd_thread_i (rd_thread_num),
    .rd_inc_i    (rd_inc_c),
    .rd_clr_i    (rd_clr_c),
    .wr_full_o   (wr_full),
    .wr_ptr_wt_o (wr_ptr_wt),
    .wr_ptr_rt_o (wr_ptr_rt),
    .rd_ptr_rt_o (rd_ptr_rt)
  );

  // During a reload cycle lk_ptr_q still belongs to the previous thread.
  assign reload_c     = (rd_thread_num != prev_thread_q);
  assign lookup_empty = reload_c | (lk_ptr_q == wr_ptr_rt);
  assign rd_addr_c    = {rd_thread_num, lk_ptr_q[LW-1:0]};
  assign wr_addr_c    = {wr_thread_num, wr_ptr_wt[LW-1:0]};
  assign dout         = mem[rd_addr_c];
  assign err          = err_q;

  always_comb begin
    rd_clr_c     = rd_en & rd_rst;
    wr_kill_c    = rd_clr_c & (wr_thread_num == rd_thread_num);
    wr_do_c      = wr_en & ~wr_full & ~wr_kill_c;
    wr_drop_c    = wr_en & wr_full & ~wr_kill_c;
    lk_do_c      = lookup_en & ~lookup_empty;
    lk_err_c     = lookup_en & lookup_empty & ~reload_c;
    lk_eff_c     = reload_c ? rd_ptr_rt : lk_ptr_q;
    commit_c     = rd_en & ~rd_rst;
    commit_err_c = commit_c & (rd_ptr_rt == lk_eff_c);
    rd_inc_c     = commit_c & ~commit_err_c;
    err_d        = err_q | wr_drop_c | lk_err_c | commit_err_c;

    lk_ptr_d = lk_ptr_q;
    if (rd_clr_c) begin
      lk_ptr_d = '0;
    end else if (reload_c) begin
      lk_ptr_d = rd_ptr_rt;
    end else if (lk_do_c) begin
      lk_ptr_d = lk_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      lk_ptr_q      <= '0;
      prev_thread_q <= '0;
      err_q         <= 1'b0;
    end else begin
      lk_ptr_q      <= lk_ptr_d;
      prev_thread_q <= rd_thread_num;
      err_q         <= err_d;
    end
  end

  // Record storage is intentionally not reset.
  always_ff @(posedge CLK) begin
    if (wr_do_c) begin
      mem[wr_addr_c] <= din;
    end
  end

endmodule

// File: tb/tb_procb_buf.sv
// Bench for procb_buf: directed table, corner sequences, and randomized
// traffic checked against a queue-based model of the buffer.
module tb_procb_buf;
  import procb_buf_pkg::*;

  localparam int unsigned NT = PROCB_N_THREADS;
  localparam int unsigned DP = PROCB_DEPTH;
  localparam int unsigned DW = PROCB_D_WIDTH;
  localparam int unsigned TW = $clog2(NT);

  typedef logic [DW-1:0] rec_t;

  typedef struct {
    int wt; bit we; int di; int rt; bit lk; bit re; bit rr;
    bit e_full; bit e_empty; int e_dout; bit e_err;
  } vec_t;

  logic          CLK;
  logic          rst_n;
  logic [TW-1:0] wr_thread_num, rd_thread_num;
  logic          wr_en, lookup_en, rd_en, rd_rst;
  rec_t          din, dout;
  logic          wr_full, lookup_empty, err;

  int   n_vec = 0;
  int   n_bad = 0;
  vec_t tbl[$];

  // Reference model: pending (uncommitted) records per thread, looked-up count
  // for the currently served thread.
  rec_t mq[NT][$];
  int   looked, prev_m, cur_rt;
  bit   err_m;

  procb_buf dut (
    .CLK           (CLK),
    .rst_n         (rst_n),
    .wr_thread_num (wr_thread_num),
    .wr_en         (wr_en),
    .din           (din),
    .wr_full       (wr_full),
    .rd_thread_num (rd_thread_num),
    .lookup_en     (lookup_en),
    .rd_en         (rd_en),
    .rd_rst        (rd_rst),
    .lookup_empty  (lookup_empty),
    .dout          (dout),
    .err           (err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic rec_t mkrec(input int i);
    procb_rec_t r;
    r.addr       = 32'h8000_0000 + 32'(i) * 32'h40;
    r.bytes_left = 16'(i * 7 + 3);
    r.finish_ctx = i[0];
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int wt, input bit we, input rec_t d, input int rt,
                       input bit lk, input bit re, input bit rr);
    wr_thread_num = TW'(wt);
    wr_en         = we;
    din           = d;
    rd_thread_num = TW'(rt);
    lookup_en     = lk;
    rd_en         = re;
    rd_rst        = rr;
  endtask

  task automatic add(input int wt, input bit we, input int di, input int rt, input bit lk,
                     input bit re, input bit rr, input bit ef, input bit ee, input int ed,
                     input bit er);
    vec_t v;
    v = '{wt, we, di, rt, lk, re, rr, ef, ee, ed, er};
    tbl.push_back(v);
  endtask

  task automatic rst_pulse();
    drive(0, 0, '0, 0, 0, 0, 0);
    rst_n = 1'b0;
    @(negedge CLK);
    rst_n = 1'b1;
  endtask

  task automatic run_random(input int cycles);
    int   wt, rt, cnt, nl;
    bit   reload, e_empty, e_full, we, lk, re, rr, clr;
    rec_t d;
    for (int c = 0; c < cycles; c++) begin
      wt = int'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) cur_rt = int'($urandom_range(0, 3));
      rt      = cur_rt;
      reload  = (rt != prev_m);
      cnt     = mq[rt].size();
      e_empty = reload || (looked == cnt);
      e_full  = (mq[wt].size() == DP);
      we      = ($urandom_range(0, 99) < (e_full ? 10 : 60));
      lk      = ($urandom_range(0, 99) < (e_empty ? 5 : 50));
      re      = ($urandom_range(0, 99) < ((!reload && looked > 0) ? 45 : 3));
      rr      = re && ($urandom_range(0, 99) < 5);
      d       = DW'({$urandom(), $urandom()});
      drive(wt, we, d, rt, lk, re, rr);
      #1;
      chk("rnd.wr_full", wr_full, e_full);
      chk("rnd.lookup_empty", lookup_empty, e_empty);
      chk("rnd.err", err, err_m);
      if (!e_empty) chk("rnd.dout", dout, mq[rt][looked]);
      clr = re && rr;
      nl  = reload ? 0 : looked;
      if (!reload && lk) begin
        if (looked < cnt) nl++;
        else err_m = 1'b1;
      end
      if (re && !rr) begin
        if (reload || looked == 0) err_m = 1'b1;
        else begin
          void'(mq[rt].pop_front());
          nl--;
        end
      end
      if (we && !(clr && wt == rt)) begin
        if (e_full) err_m = 1'b1;
        else mq[wt].push_back(d);
      end
      if (clr) begin
        mq[rt].delete();
        nl = 0;
      end
      looked = nl;
      prev_m = rt;
      @(negedge CLK);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, '0, 0, 0, 0, 0);
    repeat (2) @(negedge CLK);
    #1;
    chk("reset.wr_full", wr_full, 1'b0);
    chk("reset.lookup_empty", lookup_empty, 1'b1);
    chk("reset.err", err, 1'b0);
    @(negedge CLK);
    rst_n = 1'b1;

    // Startup sweep: init every thread.
    for (int t = 0; t < int'(NT); t++) begin
      drive(0, 0, '0, t, 0, 1, 1);
      @(negedge CLK);
    end

    //  wt we di rt lk re rr | full empty dout err
    add(3, 1, 0, 15, 0, 0, 0, 0, 1, -1, 0);
    add(3, 1, 1, 15, 0, 0, 0, 0, 1, -1, 0);
    add(3, 1, 2, 15, 0, 0, 0, 0, 1, -1, 0);
    add(3, 1, 3, 15, 0, 0, 0, 0, 1, -1, 0);
    add(3, 1, 4, 15, 0, 0, 0, 1, 1, -1, 0);  // 5th write dropped
    add(3, 0, 0,  3, 0, 0, 0, 1, 1, -1, 1);  // reload cycle
    add(3, 0, 0,  3, 0, 0, 0, 1, 0,  0, 1);
    add(3, 0, 0,  3, 1, 0, 0, 1, 0,  0, 1);
    add(3, 0, 0,  3, 1, 0, 0, 1, 0,  1, 1);
    add(3, 0, 0,  3, 1, 0, 0, 1, 0,  2, 1);
    add(3, 0, 0,  3, 1, 0, 0, 1, 0,  3, 1);
    add(3, 0, 0,  3, 0, 0, 0, 1, 1, -1, 1);
    add(3, 0, 0,  3, 0, 1, 0, 1, 1, -1, 1);  // commit rec0
    add(3, 0, 0,  5, 0, 0, 0, 0, 1, -1, 1);  // switch away
    add(3, 0, 0,  3, 0, 0, 0, 0, 1, -1, 1);  // switch back, reload
    add(3, 0, 0,  3, 0, 0, 0, 0, 0,  1, 1);  // rewound to rd_ptr=1
    add(3, 1, 5,  3, 1, 0, 0, 0, 0,  1, 1);
    add(3, 0, 0,  3, 0, 0, 0, 1, 0,  2, 1);
    add(3, 0, 0,  3, 0, 1, 0, 1, 0,  2, 1);
    add(3, 0, 0,  3, 1, 0, 0, 0, 0,  2, 1);
    add(3, 1, 6,  3, 0, 1, 0, 0, 0,  3, 1);  // write + commit same thread
    add(3, 0, 0,  3, 0, 0, 0, 0, 0,  3, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].wt, tbl[i].we, mkrec(tbl[i].di), tbl[i].rt, tbl[i].lk, tbl[i].re, tbl[i].rr);
      #1;
      chk($sformatf("tbl%0d.wr_full", i), wr_full, tbl[i].e_full);
      chk($sformatf("tbl%0d.lookup_empty", i), lookup_empty, tbl[i].e_empty);
      chk($sformatf("tbl%0d.err", i), err, tbl[i].e_err);
      if (tbl[i].e_dout >= 0) chk($sformatf("tbl%0d.dout", i), dout, mkrec(tbl[i].e_dout));
      @(negedge CLK);
    end

    // Asynchronous reset with thread 3 full and err set.
    drive(3, 1, mkrec(7), 3, 0, 0, 0);
    @(negedge CLK);
    drive(3, 0, '0, 3, 0, 0, 0);
    #1;
    chk("arst.pre_full", wr_full, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.wr_full", wr_full, 1'b0);
    chk("arst.lookup_empty", lookup_empty, 1'b1);
    chk("arst.err", err, 1'b0);
    @(negedge CLK);
    rst_n = 1'b1;
    @(negedge CLK);
    #1;
    chk("arst.t3_empty", lookup_empty, 1'b1);
    chk("arst.t3_not_full", wr_full, 1'b0);

    // Lookup on an empty thread.
    rst_pulse();
    drive(0, 0, '0, 0, 1, 0, 0);
    #1;
    chk("lkerr.empty", lookup_empty, 1'b1);
    chk("lkerr.err_before", err, 1'b0);
    @(negedge CLK);
    drive(0, 0, '0, 0, 0, 0, 0);
    #1;
    chk("lkerr.err_after", err, 1'b1);
    chk("lkerr.still_empty", lookup_empty, 1'b1);

    // Commit of an un-looked record.
    rst_pulse();
    #1;
    chk("rderr.err_cleared", err, 1'b0);
    drive(0, 1, mkrec(50), 0, 0, 0, 0);
    @(negedge CLK);
    drive(0, 0, '0, 0, 0, 1, 0);
    #1;
    chk("rderr.dout", dout, mkrec(50));
    @(negedge CLK);
    drive(0, 0, '0, 0, 0, 0, 0);
    #1;
    chk("rderr.err", err, 1'b1);
    chk("rderr.not_empty", lookup_empty, 1'b0);
    chk("rderr.dout_kept", dout, mkrec(50));
    drive(0, 0, '0, 0, 1, 0, 0);
    @(negedge CLK);
    drive(0, 0, '0, 0, 0, 1, 0);
    #1;
    chk("rderr.drained", lookup_empty, 1'b1);
    @(negedge CLK);
    drive(0, 0, '0, 0, 0, 0, 0);
    #1;
    chk("rderr.err_sticky", err, 1'b1);

    // Ring wrap on thread 7: write, look up, commit, ten times.
    rst_pulse();
    for (int i = 0; i < 10; i++) begin
      drive(7, 1, mkrec(100 + i), 7, 0, 0, 0);
      #1;
      chk($sformatf("wrap%0d.empty_pre", i), lookup_empty, 1'b1);
      @(negedge CLK);
      drive(7, 0, '0, 7, 1, 0, 0);
      #1;
      chk($sformatf("wrap%0d.dout", i), dout, mkrec(100 + i));
      @(negedge CLK);
      drive(7, 0, '0, 7, 0, 1, 0);
      #1;
      chk($sformatf("wrap%0d.empty_post", i), lookup_empty, 1'b1);
      chk($sformatf("wrap%0d.full", i), wr_full, 1'b0);
      @(negedge CLK);
    end
    drive(7, 0, '0, 7, 0, 0, 0);
    #1;
    chk("wrap.err", err, 1'b0);

    // Randomized episodes against the model.
    for (int ep = 0; ep < 6; ep++) begin
      rst_pulse();
      for (int t = 0; t < int'(NT); t++) mq[t].delete();
      looked = 0;
      prev_m = 0;
      cur_rt = 0;
      err_m  = 1'b0;
      run_random(200);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
